// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared constants and FSM encoding for the I-cache refill controller
`ifndef CACHE_WIDTH
`define CACHE_WIDTH 256
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

package icache_refill_ctrl_pkg;

    localparam int CACHE_WIDTH   = `CACHE_WIDTH;
    localparam int MEM_WIDTH_DEF = 64;
    localparam int SIZE_PC_DEF   = `SIZE_PC;
    localparam int BEATS         = CACHE_WIDTH / MEM_WIDTH_DEF;
    localparam int BLK_OFFSET_W  = $clog2(CACHE_WIDTH / 8);
    localparam int FILL_CNT_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FILL = 3'd3,
        S_COOL = 3'd4
    } refill_state_e;

endpackage

// File: rtl/refill_beat_buffer.sv
// rtl/refill_beat_buffer.sv - beat index counter and cache-block assembly register
module refill_beat_buffer
    import icache_refill_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH = MEM_WIDTH_DEF,
    parameter int N_BEATS   = BEATS,
    parameter int BEAT_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_wr,
    input  logic [MEM_WIDTH-1:0]   i_data,
    output logic                   o_last,
    output logic [CACHE_WIDTH-1:0] o_block_next
);

    logic [BEAT_W-1:0]      r_beat;
    logic [CACHE_WIDTH-1:0] r_block;
    logic [CACHE_WIDTH-1:0] w_block_next;

    // Block as it will look once the incoming beat lands; lets the top capture
    // the complete line in the same cycle the last beat arrives.
    always_comb begin
        w_block_next = r_block;
        w_block_next[int'(r_beat) * MEM_WIDTH +: MEM_WIDTH] = i_data;
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_beat  <= '0;
            r_block <= '0;
        end else if (i_wr) begin
            r_block <= w_block_next;
            r_beat  <= o_last ? '0 : r_beat + 1'b1;
        end
    end

    assign o_last       = (r_beat == BEAT_W'(N_BEATS - 1));
    assign o_block_next = w_block_next;

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache miss refill FSM: fetches one block beat-by-beat and writes it back
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH = MEM_WIDTH_DEF,
    parameter int SIZE_PC   = SIZE_PC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_i,
    input  logic [SIZE_PC-1:0]     missAddr_i,
    output logic                   wrEnable_o,
    output logic [SIZE_PC-1:0]     wrAddr_o,
    output logic [CACHE_WIDTH-1:0] instBlock_o,
    output logic                   memReq_o,
    output logic [SIZE_PC-1:0]     memAddr_o,
    input  logic                   memAck_i,
    input  logic                   memValid_i,
    input  logic [MEM_WIDTH-1:0]   memData_i,
    output logic                   busy_o,
    output logic [FILL_CNT_W-1:0]  fillCount_o
);

    localparam int N_BEATS = (MEM_WIDTH == MEM_WIDTH_DEF) ? BEATS : CACHE_WIDTH / MEM_WIDTH;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [SIZE_PC-1:0] BEAT_BYTES = SIZE_PC'(MEM_WIDTH / 8);
    localparam logic [SIZE_PC-1:0] BLK_MASK   = ~SIZE_PC'((1 << BLK_OFFSET_W) - 1);

    refill_state_e          r_state;
    logic [SIZE_PC-1:0]     r_base;
    logic                   r_mem_req;
    logic [SIZE_PC-1:0]     r_mem_addr;
    logic                   r_wr_en;
    logic [SIZE_PC-1:0]     r_wr_addr;
    logic [CACHE_WIDTH-1:0] r_inst_block;
    logic                   r_busy;
    logic [FILL_CNT_W-1:0]  r_fill_count;

    logic                   w_miss_take;
    logic                   w_beat_wr;
    logic                   w_last;
    logic [SIZE_PC-1:0]     w_miss_base;
    logic [CACHE_WIDTH-1:0] w_block_next;

    assign w_miss_base = missAddr_i & BLK_MASK;
    assign w_miss_take = (r_state == S_IDLE) && miss_i;
    // Data is only accepted while a beat is outstanding, so stale returns are dropped.
    assign w_beat_wr   = (r_state == S_WAIT) && memValid_i;

    refill_beat_buffer #(
        .MEM_WIDTH (MEM_WIDTH),
        .N_BEATS   (N_BEATS),
        .BEAT_W    (BEAT_W)
    ) u_beat_buf (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_miss_take),
        .i_wr         (w_beat_wr),
        .i_data       (memData_i),
        .o_last       (w_last),
        .o_block_next (w_block_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_inst_block <= '0;
            r_busy       <= 1'b0;
            r_fill_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (miss_i) begin
                        r_base     <= w_miss_base;
                        r_mem_addr <= w_miss_base;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (memAck_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (memValid_i) begin
                        if (w_last) begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= r_base;
                            r_inst_block <= w_block_next;
                            r_state      <= S_FILL;
                        end else begin
                            r_mem_addr <= r_mem_addr + BEAT_BYTES;
                            r_mem_req  <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_FILL: begin
                    r_fill_count <= r_fill_count + 1'b1;
                    r_state      <= S_COOL;
                end
                // One dead cycle so a miss still showing the old tag is not re-fetched.
                S_COOL: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign wrEnable_o  = r_wr_en;
    assign wrAddr_o    = r_wr_addr;
    assign instBlock_o = r_inst_block;
    assign memReq_o    = r_mem_req;
    assign memAddr_o   = r_mem_addr;
    assign busy_o      = r_busy;
    assign fillCount_o = r_fill_count;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    localparam int MW = 64;
    localparam int AW = 32;
    localparam int CW = 256;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_i;
    logic [AW-1:0] missAddr_i;
    logic          wrEnable_o;
    logic [AW-1:0] wrAddr_o;
    logic [CW-1:0] instBlock_o;
    logic          memReq_o;
    logic [AW-1:0] memAddr_o;
    logic          memAck_i;
    logic          memValid_i;
    logic [MW-1:0] memData_i;
    logic          busy_o;
    logic [15:0]   fillCount_o;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .miss_i      (miss_i),
        .missAddr_i  (missAddr_i),
        .wrEnable_o  (wrEnable_o),
        .wrAddr_o    (wrAddr_o),
        .instBlock_o (instBlock_o),
        .memReq_o    (memReq_o),
        .memAddr_o   (memAddr_o),
        .memAck_i    (memAck_i),
        .memValid_i  (memValid_i),
        .memData_i   (memData_i),
        .busy_o      (busy_o),
        .fillCount_o (fillCount_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_pos = 0;
    bit check_en = 1'b0;

    always @(posedge clk) n_pos++;

    function automatic logic [MW-1:0] beat_data(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: beats requested / received per miss, then fill and cool-down.
    bit          m_busy = 1'b0;
    bit          m_await = 1'b0;
    int          m_post = 0;
    int          m_next = 0;
    int          m_got = 0;
    logic [AW-1:0] m_base = '0;
    logic [CW-1:0] m_blk = '0;
    logic [AW-1:0] m_wr_addr = '0;
    logic [CW-1:0] m_wr_block = '0;
    logic [15:0]   m_fills = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_await = 0; m_post = 0; m_next = 0; m_got = 0;
            m_base = '0; m_fills = '0; m_wr_addr = '0; m_wr_block = '0;
        end else if (!m_busy) begin
            if (miss_i) begin
                m_busy = 1; m_base = missAddr_i & ~32'h1F;
                m_next = 0; m_got = 0; m_await = 0; m_post = 0;
            end
        end else if (m_post == 1) begin
            m_post = 2; m_fills = m_fills + 16'd1;
        end else if (m_post == 2) begin
            m_busy = 0; m_post = 0;
        end else if (m_await) begin
            if (memValid_i) begin
                m_blk[m_got*MW +: MW] = memData_i;
                m_got++;
                m_await = 0;
                if (m_got == NB) begin
                    m_post = 1; m_wr_addr = m_base; m_wr_block = m_blk;
                end
            end
        end else if (memAck_i) begin
            m_next++;
            m_await = 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", busy_o, m_busy);
            chk("memReq", memReq_o, m_busy && m_post == 0 && !m_await);
            if (m_busy && m_post == 0 && !m_await)
                chk("memAddr", memAddr_o, m_base + 32'(8 * m_next));
            chk("wrEnable", wrEnable_o, m_post == 1);
            chk("wrAddr", wrAddr_o, m_wr_addr);
            chk("instBlock", instBlock_o, m_wr_block);
            chk("fillCount", fillCount_o, m_fills);
        end
    end

    // Memory responder
    bit            pend_valid = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] stall_addr = '1;
    logic [AW-1:0] drop_addr = '1;
    int            stall_n = 0;
    int            stall_cnt = 0;
    logic [AW-1:0] ack_log[$];

    task automatic tick();
        @(negedge clk);
        memAck_i   = 1'b0;
        memValid_i = 1'b0;
        if (pend_valid) begin
            memValid_i = 1'b1;
            memData_i  = beat_data(pend_addr);
            pend_valid = 1'b0;
        end else if (memReq_o) begin
            if (memAddr_o == stall_addr && stall_cnt < stall_n) begin
                stall_cnt++;
            end else begin
                memAck_i = 1'b1;
                ack_log.push_back(memAddr_o);
                pend_addr  = memAddr_o;
                pend_valid = (memAddr_o != drop_addr);
            end
        end
    endtask

    task automatic run_fill(input logic [AW-1:0] addr, input bit drop_miss,
                            output int fill_at, output int pulses);
        int t0;
        fill_at = -1;
        pulses  = 0;
        ack_log.delete();
        miss_i     = 1'b1;
        missAddr_i = addr;
        t0 = n_pos;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (drop_miss && ack_log.size() >= 2) begin
                miss_i     = 1'b0;
                missAddr_i = 32'hDEAD_BEEF;
            end
            if (wrEnable_o) begin
                pulses++;
                if (fill_at < 0) fill_at = n_pos - t0;
                miss_i = 1'b0;
            end
            if (fill_at >= 0 && !busy_o) break;
        end
        if (fill_at < 0) chk("fill_timeout", 0, 1);
    endtask

    function automatic logic [CW-1:0] blk_of(input logic [AW-1:0] base);
        return {beat_data(base + 32'h18), beat_data(base + 32'h10),
                beat_data(base + 32'h08), beat_data(base)};
    endfunction

    int fa, np;
    int rises[$];
    bit prev_req;
    logic [AW-1:0] exp_addr[4];

    initial begin
        reset = 1'b1; miss_i = 1'b0; missAddr_i = '0;
        memAck_i = 1'b0; memValid_i = 1'b0; memData_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;
        chk("rst_busy", busy_o, 0);
        chk("rst_fill_count", fillCount_o, 0);
        chk("rst_wraddr", wrAddr_o, 0);
        chk("rst_block", instBlock_o, 0);

        // Basic fill at 0x1234
        exp_addr = '{32'h1220, 32'h1228, 32'h1230, 32'h1238};
        run_fill(32'h0000_1234, 0, fa, np);
        chk("t1_fill_cycle", fa, 9);
        chk("t1_pulses", np, 1);
        chk("t1_nacks", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            chk("t1_memaddr", ack_log[i], exp_addr[i]);
        chk("t1_wraddr", wrAddr_o, 32'h1220);
        chk("t1_block", instBlock_o,
            {64'h5A5A_1238_FFFF_EDC7, 64'h5A5A_1230_FFFF_EDCF,
             64'h5A5A_1228_FFFF_EDD7, 64'h5A5A_1220_FFFF_EDDF});
        chk("t1_count", fillCount_o, 1);

        // Ack withheld 5 cycles on beat 2
        stall_addr = 32'h1230; stall_n = 5; stall_cnt = 0;
        run_fill(32'h0000_1234, 0, fa, np);
        chk("t2_fill_cycle", fa, 14);
        chk("t2_stalls", stall_cnt, 5);
        chk("t2_block", instBlock_o, blk_of(32'h1220));
        chk("t2_count", fillCount_o, 2);
        stall_addr = '1;

        // Miss drops after beat 1, address garbage afterwards
        run_fill(32'h0000_4568, 1, fa, np);
        chk("t3_fill_cycle", fa, 9);
        chk("t3_pulses", np, 1);
        chk("t3_wraddr", wrAddr_o, 32'h4560);
        chk("t3_block", instBlock_o, blk_of(32'h4560));
        chk("t3_count", fillCount_o, 3);

        // Reset in WAIT of beat 3, stale valid afterwards
        drop_addr = 32'h2018;
        ack_log.delete();
        miss_i = 1'b1; missAddr_i = 32'h2004;
        for (int i = 0; i < 60 && ack_log.size() < 4; i++) tick();
        chk("t4_reached_beat3", ack_log.size(), 4);
        miss_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        memValid_i = 1'b1; memData_i = 64'hBAD0_BAD0_BAD0_BAD0;
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wrEnable_o) np++;
        end
        chk("t4_no_fill", np, 0);
        chk("t4_busy", busy_o, 0);
        chk("t4_count", fillCount_o, 0);
        chk("t4_block", instBlock_o, 0);
        drop_addr = '1;
        run_fill(32'h0000_2000, 0, fa, np);
        chk("t4_refill_cycle", fa, 9);
        chk("t4_refill_block", instBlock_o, blk_of(32'h2000));
        chk("t4_refill_count", fillCount_o, 1);

        // Miss held through FILL/COOL: second fetch only after the IDLE cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rises.delete();
        prev_req = 1'b0;
        np = 0;
        miss_i = 1'b1; missAddr_i = 32'h3010;
        fa = n_pos;
        for (int i = 0; i < 100 && np < 2; i++) begin
            tick();
            if (memReq_o && !prev_req) rises.push_back(n_pos - fa);
            prev_req = memReq_o;
            if (wrEnable_o) np++;
        end
        miss_i = 1'b0;
        for (int i = 0; i < 10 && busy_o; i++) tick();
        chk("t5_fills", np, 2);
        chk("t5_nrises", rises.size(), 8);
        if (rises.size() > 4) chk("t5_second_req_cycle", rises[4], 12);
        chk("t5_count", fillCount_o, 2);
        chk("t5_block", instBlock_o, blk_of(32'h3000));

        // Counter wrap
        @(posedge clk);
        #2;
        force dut.r_fill_count = 16'hFFFF;
        m_fills = 16'hFFFF;
        @(posedge clk);
        #2;
        release dut.r_fill_count;
        tick();
        chk("t6_preload", fillCount_o, 16'hFFFF);
        run_fill(32'h0000_1234, 0, fa, np);
        chk("t6_wrap", fillCount_o, 16'h0000);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
